// File: rtl/cfg_frame_con_if.sv
// rtl/cfg_frame_con_if.sv - serial-in / per-block-out configuration bus bundle
interface cfg_frame_con_if #(
  parameter int N_BLOCKS = 77,
  parameter int IDX_W    = 7
);
  logic                MASTER_DIN;
  logic                MASTER_EN;
  logic                CH_ADDR;
  logic                AUTO_ADV;
  logic                PROG_DONE;
  logic [N_BLOCKS-1:0] BLOCK_SEL;
  logic [N_BLOCKS-1:0] BLOCK_DIN;
  logic [N_BLOCKS-1:0] BLOCK_WE;
  logic [IDX_W-1:0]    BLK_IDX;
  logic                FRAME_OK;
  logic                DONE;
  logic                ERR;

  modport master (
    output MASTER_DIN, MASTER_EN, CH_ADDR, AUTO_ADV, PROG_DONE,
    input  BLOCK_SEL, BLOCK_DIN, BLOCK_WE, BLK_IDX, FRAME_OK, DONE, ERR
  );

  modport slave (
    input  MASTER_DIN, MASTER_EN, CH_ADDR, AUTO_ADV, PROG_DONE,
    output BLOCK_SEL, BLOCK_DIN, BLOCK_WE, BLK_IDX, FRAME_OK, DONE, ERR
  );
endinterface

// File: rtl/cfg_frame_con.sv
// rtl/cfg_frame_con.sv - distributes a serial configuration stream into fixed-length frames per block
module cfg_frame_con #(
  parameter int N_BLOCKS = 77,
  parameter int FRAME_W  = 18,
  parameter int IDX_W    = 7
) (
  input logic          CLK,
  input logic          RST,
  cfg_frame_con_if.slave bus
);
  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
  localparam logic [IDX_W-1:0] LAST_BLK = IDX_W'(N_BLOCKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERROR} state_t;

  state_t              state_q, state_d;
  logic [N_BLOCKS-1:0] sel_q, sel_d;
  logic [N_BLOCKS-1:0] din_q, din_d;
  logic [N_BLOCKS-1:0] we_q, we_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                fok_q, fok_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                fin_pend_q, fin_pend_d;

  logic                at_zero, last_bit, last_blk, adv_pre, adv_post;
  logic [N_BLOCKS-1:0] lane;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    din_d      = '0;
    we_d       = '0;
    fok_d      = 1'b0;
    done_d     = done_q;
    err_d      = err_q;
    fin_pend_d = fin_pend_q;
    at_zero    = (cnt_q == '0);
    last_bit   = bus.MASTER_EN && (cnt_q == LAST_BIT);
    last_blk   = (idx_q == LAST_BLK);
    adv_pre    = bus.CH_ADDR && at_zero;
    adv_post   = last_bit && (bus.CH_ADDR || bus.AUTO_ADV);
    lane       = adv_pre ? (sel_q << 1) : sel_q;

    case (state_q)
      S_IDLE, S_LOAD: begin
        // The final write of the last block is delivered before DONE takes over.
        if (fin_pend_q) begin
          state_d    = S_DONE;
          sel_d      = '0;
          done_d     = 1'b1;
          fin_pend_d = 1'b0;
        end else if (bus.PROG_DONE) begin
          sel_d = '0;
          if (at_zero) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end else if (bus.CH_ADDR && !at_zero && !last_bit) begin
          state_d = S_ERROR;
          sel_d   = '0;
          err_d   = 1'b1;
        end else if (adv_pre && last_blk) begin
          state_d = S_DONE;
          sel_d   = '0;
          done_d  = 1'b1;
        end else begin
          if (adv_pre) begin
            sel_d = sel_q << 1;
            idx_d = idx_q + IDX_W'(1);
          end
          if (bus.MASTER_EN) begin
            state_d = S_LOAD;
            we_d    = lane;
            din_d   = bus.MASTER_DIN ? lane : '0;
            if (last_bit) begin
              cnt_d = '0;
              fok_d = 1'b1;
              if (adv_post) begin
                if (last_blk) begin
                  fin_pend_d = 1'b1;
                end else begin
                  sel_d = sel_q << 1;
                  idx_d = idx_q + IDX_W'(1);
                end
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      sel_q      <= N_BLOCKS'(1);
      din_q      <= '0;
      we_q       <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      fok_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      fin_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      din_q      <= din_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      fok_q      <= fok_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fin_pend_q <= fin_pend_d;
    end
  end

  assign bus.BLOCK_SEL = sel_q;
  assign bus.BLOCK_DIN = din_q;
  assign bus.BLOCK_WE  = we_q;
  assign bus.BLK_IDX   = idx_q;
  assign bus.FRAME_OK  = fok_q;
  assign bus.DONE      = done_q;
  assign bus.ERR       = err_q;
endmodule

// File: doc/cfg_frame_con.md
CFG_FRAME_CON -- requirements
Module: cfg_frame_con

Interface
REQ-001 Parameter N_BLOCKS, default 77: number of configuration blocks; range 2..256.
REQ-002 Parameter FRAME_W, default 18: bits per block frame; range 2..1024.
REQ-003 Parameter IDX_W, default 7: BLK_IDX width; SHALL be at least ceil(log2(N_BLOCKS)).
REQ-004 Ports SHALL be:
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- MASTER_DIN  in  1  serial configuration bit.
- MASTER_EN  in  1  bit-valid qualifier for MASTER_DIN.
- CH_ADDR  in  1  single-cycle request to advance to the next block.
- AUTO_ADV  in  1  1 = advance automatically after each full frame; 0 = advance only on CH_ADDR.
- PROG_DONE  in  1  end of programming.
- BLOCK_SEL  out  N_BLOCKS  one-hot selected block.
- BLOCK_DIN  out  N_BLOCKS  serial data to the selected block; 0 on all other lanes.
- BLOCK_WE  out  N_BLOCKS  bit strobe to the selected block.
- BLK_IDX  out  IDX_W  binary index of the selected block.
- FRAME_OK  out  1  one-cycle pulse on frame completion.
- DONE  out  1  sticky programming-complete flag.
- ERR  out  1  sticky protocol-error flag.
REQ-005 The block SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-006 The FSM states SHALL be IDLE, LOAD, DONE and ERROR; all outputs SHALL be registered.
REQ-007 IDLE SHALL go to LOAD on the first cycle with MASTER_EN=1, and that bit SHALL be accepted.
REQ-008 In LOAD, each cycle with MASTER_EN=1 SHALL accept one bit, then on the next edge set BLOCK_DIN[BLK_IDX]=MASTER_DIN and BLOCK_WE[BLK_IDX]=1 (1-cycle latency).
REQ-009 In cycles with MASTER_EN=0, BLOCK_WE SHALL be 0, BLOCK_DIN SHALL be 0 and the bit counter SHALL hold.
REQ-010 The bit counter SHALL count 0..FRAME_W-1; accepting bit FRAME_W-1 SHALL reset it to 0 and pulse FRAME_OK in the same cycle as the final BLOCK_WE.
REQ-011 With AUTO_ADV=1 at frame completion, BLOCK_SEL SHALL shift to the next block and BLK_IDX SHALL increment, both effective on the edge that raises FRAME_OK; the next accepted bit SHALL go to the new block.
REQ-012 A CH_ADDR pulse with bit counter = 0 SHALL advance the selection by one block on the next edge.
REQ-013 CH_ADDR arriving in the same cycle as the final frame bit:
- the bit SHALL go to the current block;
- the selection SHALL advance exactly once, even with AUTO_ADV=1.
REQ-014 CH_ADDR with the bit counter at 1..FRAME_W-1 (short frame) SHALL enter ERROR.
REQ-015 With AUTO_ADV=0, a bit accepted after a completed frame without an intervening CH_ADDR SHALL be written to the same block as a new frame; this is not an error.
REQ-016 Advancing past block N_BLOCKS-1 SHALL NOT wrap; it SHALL enter DONE.
REQ-017 PROG_DONE=1 in IDLE or LOAD:
- with bit counter 0, SHALL enter DONE;
- otherwise SHALL enter ERROR.
- PROG_DONE SHALL take priority over CH_ADDR and MASTER_EN in the same cycle; the bit that cycle is discarded.
REQ-018 In DONE, DONE SHALL be 1 and BLOCK_SEL, BLOCK_WE and BLOCK_DIN SHALL be 0; all inputs SHALL be ignored until RST.
REQ-019 In ERROR, ERR SHALL be 1 and BLOCK_SEL, BLOCK_WE and BLOCK_DIN SHALL be 0; all inputs SHALL be ignored until RST.
REQ-020 BLOCK_SEL SHALL be one-hot in IDLE and LOAD, and all-zero in DONE and ERROR.

Reset
REQ-021 RST=1 SHALL, on the next edge, force IDLE with:
- BLOCK_SEL = 1 (block 0), BLK_IDX = 0, bit counter = 0;
- BLOCK_DIN = 0, BLOCK_WE = 0, FRAME_OK = 0, DONE = 0, ERR = 0.
REQ-022 RST SHALL override all other inputs, including mid-frame, DONE and ERROR.

Verification (N_BLOCKS=4, FRAME_W=18, pattern P=18'b101001010010110100 sent LSB first)
REQ-023 Manual mode:
- stimulus: AUTO_ADV=0; P to block 0; CH_ADDR; P; CH_ADDR; P.
- required: BLOCK_WE[0..2] each pulse 18 times, BLOCK_DIN lanes reproduce P, FRAME_OK pulses 3 times, BLK_IDX 0->1->2, ERR=0.
REQ-024 Auto mode:
- stimulus: AUTO_ADV=1; 72 contiguous bits of P repeated.
- required: 4 FRAME_OK pulses, BLK_IDX 0->1->2->3, then DONE=1 and BLOCK_SEL=0 one cycle after the 72nd bit.
REQ-025 Short frame:
- stimulus: 10 bits, then CH_ADDR.
- required: ERR=1 on the next edge, BLOCK_SEL=0, later bits produce no BLOCK_WE.
REQ-026 Simultaneous events:
- CH_ADDR with the 18th bit, AUTO_ADV=1 -> single advance to BLK_IDX=1.
- PROG_DONE with bit counter 0 -> DONE=1; PROG_DONE at bit 5 -> ERR=1.
REQ-027 Reset mid-frame:
- stimulus: RST at bit 9 of block 2.
- required: next edge BLK_IDX=0, BLOCK_SEL=4'b0001, all flags 0; a fresh P loads block 0 correctly.
